uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among four byte requesters.
// It also applies deferred baud/parity changes between frames and aborts any frame that does not complete in time.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 300000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ack,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_baud_rate,
    input  logic        cfg_parity_type,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [1:0]  baud_rate,
    output logic        parity_type,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] BAUD_RST = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       last_grant, last_grant_nxt;
    logic             cfg_pend, cfg_pend_nxt;
    logic [1:0]       pend_baud, pend_baud_nxt;
    logic             pend_parity, pend_parity_nxt;

    logic             tx_start_nxt;
    logic [7:0]       tx_data_nxt;
    logic [3:0]       req_ack_nxt;
    logic [1:0]       grant_id_nxt;
    logic             busy_nxt;
    logic             timeout_err_nxt;
    logic [1:0]       baud_rate_nxt;
    logic             parity_type_nxt;

    logic [1:0]       win;
    logic             win_found;
    logic [1:0]       rr_idx;

    // Round-robin search starting just after the last requester served
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        rr_idx    = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            rr_idx = last_grant + 2'(i);
            if (!win_found && req_valid[rr_idx]) begin
                win       = rr_idx;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        last_grant_nxt  = last_grant;
        cfg_pend_nxt    = cfg_pend;
        pend_baud_nxt   = pend_baud;
        pend_parity_nxt = pend_parity;
        tx_start_nxt    = 1'b0;
        req_ack_nxt     = '0;
        timeout_err_nxt = 1'b0;
        tx_data_nxt     = tx_data;
        grant_id_nxt    = grant_id;
        busy_nxt        = busy;
        baud_rate_nxt   = baud_rate;
        parity_type_nxt = parity_type;

        case (state)
            IDLE: begin
                // A pending config change consumes the idle slot before any launch
                if (cfg_pend) begin
                    baud_rate_nxt   = pend_baud;
                    parity_type_nxt = pend_parity;
                    cfg_pend_nxt    = 1'b0;
                end else if (win_found) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = req_data[{win, 3'b000} +: 8];
                    req_ack_nxt  = 4'(1) << win;
                    grant_id_nxt = win;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    busy_nxt       = 1'b0;
                    last_grant_nxt = grant_id;
                    state_nxt      = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_err_nxt = 1'b1;
                    busy_nxt        = 1'b0;
                    last_grant_nxt  = grant_id;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Capture wins over the clear so a write in the apply cycle is not lost
        if (cfg_wr) begin
            cfg_pend_nxt    = 1'b1;
            pend_baud_nxt   = cfg_baud_rate;
            pend_parity_nxt = cfg_parity_type;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt         <= '0;
            last_grant  <= 2'd3;
            cfg_pend    <= 1'b0;
            pend_baud   <= BAUD_RST;
            pend_parity <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            req_ack     <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            baud_rate   <= BAUD_RST;
            parity_type <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            last_grant  <= last_grant_nxt;
            cfg_pend    <= cfg_pend_nxt;
            pend_baud   <= pend_baud_nxt;
            pend_parity <= pend_parity_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            req_ack     <= req_ack_nxt;
            grant_id    <= grant_id_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
            baud_rate   <= baud_rate_nxt;
            parity_type <= parity_type_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by randomized traffic.
// Random traffic is checked against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned T = 16;
    localparam int unsigned N_RAND = 3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        cfg_wr;
    logic [1:0]  cfg_baud_rate;
    logic        cfg_parity_type;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  baud_rate;
    logic        parity_type;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .cfg_wr(cfg_wr), .cfg_baud_rate(cfg_baud_rate), .cfg_parity_type(cfg_parity_type),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .baud_rate(baud_rate), .parity_type(parity_type), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tx_start"},    32'(tx_start),    32'd0);
        chk({tag, ".tx_data"},     32'(tx_data),     32'd0);
        chk({tag, ".req_ack"},     32'(req_ack),     32'd0);
        chk({tag, ".grant_id"},    32'(grant_id),    32'd0);
        chk({tag, ".busy"},        32'(busy),        32'd0);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, ".baud_rate"},   32'(baud_rate),   32'd2);
        chk({tag, ".parity_type"}, 32'(parity_type), 32'd0);
    endtask

    // Round-robin rule: first set requester after the last one served, wrapping mod 4
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] v);
        for (int i = 1; i <= 4; i++) begin
            int idx;
            idx = (int'(last) + i) % 4;
            if (v[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        td, cw, cp;
        logic [1:0]  cb;
        bit          m_busy, m_pend, m_st, m_to;
        int          m_start;
        logic [1:0]  m_grant, m_last, m_pb, m_baud, w;
        logic        m_pp, m_par;
        logic [7:0]  m_data;
        logic [3:0]  m_ack;

        rstn = 1'b0; req_valid = '0; req_data = '0; cfg_wr = 1'b0;
        cfg_baud_rate = '0; cfg_parity_type = 1'b0; tx_done = 1'b0;
        @(negedge clk);
        tick();
        chk_reset("por");
        rstn = 1'b1;

        // Single launch and completion
        req_valid = 4'b0001; req_data = 32'h0000_00A3;
        tick();
        chk("basic.tx_start", 32'(tx_start), 32'd1);
        chk("basic.tx_data",  32'(tx_data),  32'hA3);
        chk("basic.req_ack",  32'(req_ack),  32'b0001);
        chk("basic.busy",     32'(busy),     32'd1);
        req_valid = 4'b0000;
        tick();
        chk("basic.start_pulse", 32'({tx_start, req_ack}), 32'd0);
        chk("basic.busy_hold",   32'(busy), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("basic.busy_clr", 32'(busy), 32'd0);
        tick();
        chk("basic.data_held", 32'(tx_data), 32'hA3);

        // Stray done while idle
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_done", 32'({tx_start, busy, timeout_err}), 32'd0);

        // Round-robin with all requesters held
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req_valid = 4'b1111; req_data = 32'h4433_2211;
        tick();
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            chk("rr.tx_start", 32'(tx_start), 32'd1);
            chk("rr.grant_id", 32'(grant_id), 32'(e));
            chk("rr.req_ack",  32'(req_ack),  32'(1 << e));
            chk("rr.tx_data",  32'(tx_data),  32'(8'h11 * (e + 1)));
            if (g == 4) req_valid = 4'b0000;
            repeat (11) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("rr.gap", 32'({busy, tx_start}), 32'd0);
            tick();
        end

        // Config written mid-frame is deferred, then applied ahead of a waiting request
        req_valid = 4'b0001; req_data = 32'h0000_005A;
        tick();
        chk("cfg.first_grant", 32'({tx_start, req_ack, tx_data}), {19'd0, 1'b1, 4'b0001, 8'h5A});
        req_valid = 4'b0000;
        tick();
        cfg_wr = 1'b1; cfg_baud_rate = 2'b11; cfg_parity_type = 1'b1;
        tick();
        cfg_wr = 1'b0;
        req_valid = 4'b0100; req_data = 32'h00C7_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cfg.hold_wait", 32'({baud_rate, parity_type}), 32'b100);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("cfg.hold_idle", 32'({busy, baud_rate, parity_type}), 32'b0100);
        tick();
        chk("cfg.applied", 32'({baud_rate, parity_type}), 32'b111);
        chk("cfg.no_launch", 32'(tx_start), 32'd0);
        tick();
        chk("cfg.then_launch", 32'({tx_start, grant_id, tx_data, req_ack}), {17'd0, 1'b1, 2'd2, 8'hC7, 4'b0100});

        // Timeout: no done for the whole window
        req_valid = 4'b1001; req_data = 32'hE100_00B0;
        repeat (T - 1) tick();
        chk("to.before", 32'({timeout_err, busy}), 32'b01);
        tick();
        chk("to.pulse", 32'({timeout_err, busy, tx_start}), 32'b100);
        tick();
        chk("to.next_grant", 32'({timeout_err, tx_start, grant_id, tx_data, req_ack}),
            {17'd0, 1'b0, 1'b1, 2'd3, 8'hE1, 4'b1000});

        // Done coincident with the last timeout cycle
        req_valid = 4'b0000;
        repeat (T - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("coinc.no_err", 32'({timeout_err, busy}), 32'd0);
        tick();
        chk("coinc.no_late_err", 32'(timeout_err), 32'd0);

        // Request withdrawn before service is dropped
        req_valid = 4'b0001; req_data = 32'h0000_0066;
        tick();
        chk("drop.grant0", 32'({tx_start, grant_id}), 32'b100);
        req_valid = 4'b0010;
        repeat (2) tick();
        req_valid = 4'b0000;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("drop.no_launch", 32'({tx_start, req_ack, grant_id}), 32'd0);

        // Reset in the middle of a frame restores every output
        cfg_wr = 1'b1; cfg_baud_rate = 2'b01; cfg_parity_type = 1'b1;
        tick();
        cfg_wr = 1'b0;
        tick();
        chk("rstmid.cfg", 32'({baud_rate, parity_type}), 32'b011);
        req_valid = 4'b0001; req_data = 32'h0000_0077;
        tick();
        req_valid = 4'b0000;
        tick();
        rstn = 1'b0;
        tick();
        chk_reset("rstmid");
        rstn = 1'b1;
        tick();
        chk("rstmid.after", 32'({tx_start, req_ack, busy}), 32'd0);

        // Randomized traffic against the reference model
        rstn = 1'b0; req_valid = '0; tx_done = 1'b0; cfg_wr = 1'b0;
        tick();
        rstn = 1'b1;
        rv = '0; rd = '0;
        m_busy = 1'b0; m_pend = 1'b0; m_start = 0;
        m_grant = 2'd0; m_last = 2'd3; m_pb = 2'd0; m_pp = 1'b0;
        m_baud = 2'b10; m_par = 1'b0; m_data = 8'h00;
        for (int k = 0; k < int'(N_RAND); k++) begin
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) rv[i] = 1'b0;
                else if (rv[i] && ($urandom % 16 == 0)) rv[i] = 1'b0;
                else if (!rv[i] && ($urandom % 3 == 0)) begin
                    rv[i] = 1'b1;
                    rd[8*i +: 8] = 8'($urandom);
                end
            end
            td = ($urandom % 8 == 0);
            cw = ($urandom % 12 == 0);
            cb = 2'($urandom);
            cp = 1'($urandom);
            req_valid = rv; req_data = rd; tx_done = td;
            cfg_wr = cw; cfg_baud_rate = cb; cfg_parity_type = cp;

            m_st = 1'b0; m_ack = '0; m_to = 1'b0;
            if (m_busy) begin
                if (td) begin
                    m_busy = 1'b0; m_last = m_grant;
                end else if (k - m_start == int'(T) - 1) begin
                    m_to = 1'b1; m_busy = 1'b0; m_last = m_grant;
                end
            end else if (m_pend) begin
                m_baud = m_pb; m_par = m_pp; m_pend = 1'b0;
            end else if (rv != 4'b0000) begin
                w = rr_pick(m_last, rv);
                m_st = 1'b1; m_ack = 4'(1) << w; m_grant = w;
                m_data = rd[8*w +: 8]; m_busy = 1'b1; m_start = k + 1;
            end
            if (cw) begin
                m_pend = 1'b1; m_pb = cb; m_pp = cp;
            end

            tick();
            chk("rand", 32'({tx_start, req_ack, tx_data, grant_id, busy, timeout_err, baud_rate, parity_type}),
                32'({m_st, m_ack, m_data, m_grant, m_busy, m_to, m_baud, m_par}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
